serial_frame_tx: RTL and testbench

Parallel-in, serial-out frame transmitter: the sending end for the team's D-flip-flop capture chains and shift-register receivers. A word is loaded on request and shifted out LSB first, wrapped in a start bit (0) and a stop bit (1). Each bit is held for a programmable number of clock cycles. The block sits between switch/register sources and a single serial line that drives a DFF-based receiver or an LED.

---
 rtl/serial_frame_tx_if.sv | 21 ++
 rtl/serial_frame_tx.sv | 100 ++++++++++
 tb/tb_serial_frame_tx.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/serial_frame_tx_if.sv
// Frame request and serial-line signals of serial_frame_tx.
// The source side (switches/registers) uses master; the transmitter uses slave.
interface serial_frame_tx_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  input_load3_3;
  logic [DATA_WIDTH-1:0] input_data4_4;
  logic                  output_serial5_5;
  logic                  output_busy6_6;
  logic                  output_done7_7;

  modport master (
    output input_load3_3, input_data4_4,
    input  output_serial5_5, output_busy6_6, output_done7_7
  );

  modport slave (
    input  input_load3_3, input_data4_4,
    output output_serial5_5, output_busy6_6, output_done7_7
  );
endinterface

// File: rtl/serial_frame_tx.sv
// Parallel-in, serial-out frame transmitter.
// Frame on the line: start bit (0), DATA_WIDTH payload bits LSB first, stop bit (1).
// Each bit is held BIT_CYCLES clocks. All outputs are driven straight from flops.
module serial_frame_tx #(
  parameter int DATA_WIDTH = 8,
  parameter int BIT_CYCLES = 1
) (
  input logic          input_clock1_1,
  input logic          input_reset2_2,
  serial_frame_tx_if.slave bus
);
  localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam int CNT_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] shreg;
  logic [DATA_WIDTH-1:0] shreg_nxt;
  logic [IDX_W-1:0]      idx;
  logic [CNT_W-1:0]      cnt;
  logic                  serial;
  logic                  busy;
  logic                  done;

  // Next payload bit to present once the current one has been held long enough.
  assign shreg_nxt = shreg >> 1;

  // Frame sequencer; outputs are set on the edge that enters each bit so
  // they change together with the state and never depend on live inputs.
  always_ff @(posedge input_clock1_1 or posedge input_reset2_2) begin
    if (input_reset2_2) begin
      state  <= IDLE;
      shreg  <= '0;
      idx    <= '0;
      cnt    <= '0;
      serial <= 1'b1;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          serial <= 1'b1;
          busy   <= 1'b0;
          if (bus.input_load3_3) begin
            shreg  <= bus.input_data4_4;
            cnt    <= '0;
            idx    <= '0;
            serial <= 1'b0;
            busy   <= 1'b1;
            state  <= START;
          end
        end
        START: begin
          if (cnt == CNT_LAST) begin
            cnt    <= '0;
            serial <= shreg[0];
            state  <= DATA;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DATA: begin
          if (cnt == CNT_LAST) begin
            cnt <= '0;
            if (idx == IDX_LAST) begin
              serial <= 1'b1;
              state  <= STOP;
            end else begin
              idx    <= idx + IDX_W'(1);
              shreg  <= shreg_nxt;
              serial <= shreg_nxt[0];
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        STOP: begin
          if (cnt == CNT_LAST) begin
            cnt    <= '0;
            busy   <= 1'b0;
            done   <= 1'b1;
            serial <= 1'b1;
            state  <= IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.output_serial5_5 = serial;
  assign bus.output_busy6_6   = busy;
  assign bus.output_done7_7   = done;
endmodule

// File: tb/tb_serial_frame_tx.sv
// Scoreboard bench for serial_frame_tx: two instances (BIT_CYCLES=1 and 4).
// Stimulus pushes the expected per-cycle {serial,busy,done} sequence of each
// frame it launches; a monitor per instance pops one entry every cycle and
// expects the idle pattern whenever its queue is empty.
module tb_serial_frame_tx;
  typedef struct packed {
    logic serial;
    logic busy;
    logic done;
  } obs_t;

  localparam obs_t IDLE_OBS = 3'b100;
  localparam obs_t DONE_OBS = 3'b101;

  logic clk = 1'b0;
  logic rst;
  logic clk_run = 1'b0;
  int   checks = 0;
  int   failures = 0;
  obs_t q_a[$];
  obs_t q_b[$];

  serial_frame_tx_if #(.DATA_WIDTH(8)) bus_a ();
  serial_frame_tx_if #(.DATA_WIDTH(8)) bus_b ();

  serial_frame_tx #(.DATA_WIDTH(8), .BIT_CYCLES(1)) dut_a (
    .input_clock1_1(clk),
    .input_reset2_2(rst),
    .bus(bus_a.slave)
  );

  serial_frame_tx #(.DATA_WIDTH(8), .BIT_CYCLES(4)) dut_b (
    .input_clock1_1(clk),
    .input_reset2_2(rst),
    .bus(bus_b.slave)
  );

  initial begin
    wait (clk_run);
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input obs_t act, input obs_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t serial/busy/done got=%b required=%b", name, $time, act, exp);
    end
  endtask

  // Monitors: one expected observation per cycle, sampled on the falling edge.
  always @(negedge clk) begin
    obs_t ea;
    ea = (q_a.size() > 0) ? q_a.pop_front() : IDLE_OBS;
    chk("a_cycle", {bus_a.output_serial5_5, bus_a.output_busy6_6, bus_a.output_done7_7}, ea);
  end

  always @(negedge clk) begin
    obs_t eb;
    eb = (q_b.size() > 0) ? q_b.pop_front() : IDLE_OBS;
    chk("b_cycle", {bus_b.output_serial5_5, bus_b.output_busy6_6, bus_b.output_done7_7}, eb);
  end

  // pat[j] is the line level of frame bit j (j=0 start, j=9 stop), hand-written.
  task automatic push_frame(input bit sel_b, input logic [9:0] pat, input int bc);
    for (int j = 0; j < 10; j++)
      for (int r = 0; r < bc; r++)
        if (sel_b) q_b.push_back({pat[j], 1'b1, 1'b0});
        else       q_a.push_back({pat[j], 1'b1, 1'b0});
    if (sel_b) q_b.push_back(DONE_OBS);
    else       q_a.push_back(DONE_OBS);
  endtask

  // Loads a word so it is accepted at the next rising edge; returns 2ns after it.
  task automatic load_frame(input bit sel_b, input logic [7:0] d,
                            input logic [9:0] pat, input int bc);
    @(negedge clk);
    #2;
    if (sel_b) begin bus_b.input_load3_3 = 1'b1; bus_b.input_data4_4 = d; end
    else       begin bus_a.input_load3_3 = 1'b1; bus_a.input_data4_4 = d; end
    push_frame(sel_b, pat, bc);
    @(posedge clk);
    #2;
    bus_a.input_load3_3 = 1'b0;
    bus_b.input_load3_3 = 1'b0;
  endtask

  initial begin
    int guard;
    bus_a.input_load3_3 = 1'b0;
    bus_a.input_data4_4 = 8'h00;
    bus_b.input_load3_3 = 1'b0;
    bus_b.input_data4_4 = 8'h00;
    rst = 1'b1;

    // Reset values with no clock running.
    #3;
    chk("a_reset", {bus_a.output_serial5_5, bus_a.output_busy6_6, bus_a.output_done7_7}, IDLE_OBS);
    chk("b_reset", {bus_b.output_serial5_5, bus_b.output_busy6_6, bus_b.output_done7_7}, IDLE_OBS);
    #2;
    rst = 1'b0;
    clk_run = 1'b1;
    repeat (5) @(posedge clk);

    // Basic frame 0xA5: 0,1,0,1,0,0,1,0,1,1 then done.
    load_frame(1'b0, 8'hA5, 10'b1101001010, 1);
    repeat (14) @(posedge clk);

    // Bit hold time: 0x3C with 4 cycles per bit, done 40 cycles after accept.
    load_frame(1'b1, 8'h3C, 10'b1001111000, 4);
    repeat (46) @(posedge clk);

    // Load of 0xFF during a 0x00 frame is ignored; data stays 0xFF afterwards.
    load_frame(1'b0, 8'h00, 10'b1000000000, 1);
    repeat (2) @(posedge clk);
    #2;
    bus_a.input_load3_3 = 1'b1;
    bus_a.input_data4_4 = 8'hFF;
    @(posedge clk);
    #2;
    bus_a.input_load3_3 = 1'b0;
    repeat (15) @(posedge clk);

    // Back-to-back: 0x01, then 0x80 loaded in the done cycle.
    load_frame(1'b0, 8'h01, 10'b1000000010, 1);
    repeat (10) @(posedge clk);
    load_frame(1'b0, 8'h80, 10'b1100000000, 1);
    repeat (14) @(posedge clk);

    // Mid-frame asynchronous reset during data bit 3 of 0x55.
    load_frame(1'b0, 8'h55, 10'b1010101010, 1);
    repeat (4) @(posedge clk);
    #2;
    rst = 1'b1;
    q_a.delete();
    #1;
    chk("a_midreset", {bus_a.output_serial5_5, bus_a.output_busy6_6, bus_a.output_done7_7}, IDLE_OBS);
    repeat (3) @(posedge clk);
    #3;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    load_frame(1'b0, 8'h0F, 10'b1000011110, 1);

    // Drain both scoreboards within a bounded number of cycles.
    guard = 0;
    while ((q_a.size() > 0 || q_b.size() > 0) && guard < 200) begin
      @(posedge clk);
      guard++;
    end
    checks++;
    if (q_a.size() > 0 || q_b.size() > 0) begin
      failures++;
      $display("FAIL drain got=%0d/%0d entries left required=0/0", q_a.size(), q_b.size());
    end
    repeat (4) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
